// File: rtl/nixie_display_ctrl.sv
// nixie_display_ctrl
// Round-robin arbiter that hands a 4-digit nixie/7-seg display to one of
// four requesters at a time, with a minimum dwell per owner. It latches the
// owner's 16-bit value into four digit nibbles and generates the scanner's
// digit-multiplex clock enable.
module nixie_display_ctrl #(
  parameter int HOLD_CYCLES = 50_000_000,  // minimum dwell per owner, >= 2
  parameter int SCAN_DIV    = 50_000       // scan tick period, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] data_in,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic [3:0]  num_C3,
  output logic [3:0]  num_C2,
  output logic [3:0]  num_C1,
  output logic [3:0]  num_C0,
  output logic        blank,
  output logic        scan_tick
);

  localparam int DW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t        state_q;
  logic [3:0]    grant_q;
  logic [1:0]    owner_q;
  logic          blank_q;
  logic [DW-1:0] dwell_q;
  logic [15:0]   digits_q;
  logic [SW-1:0] scan_cnt_q;
  logic          scan_tick_q;

  // Round-robin result: search starts one past the current owner and ends on
  // the owner itself, so the owner only wins again when nobody else asks.
  logic       rr_found;
  logic [1:0] rr_idx;
  logic [3:0] rr_onehot;
  logic [1:0] rr_cand;
  logic       owner_req;
  logic [15:0] owner_data;

  // Nearest pending requester, counting forward from owner+1 with wrap
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner_q;
    rr_cand  = owner_q;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = owner_q + 2'(i);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign rr_onehot  = 4'b0001 << rr_idx;
  assign owner_req  = req[owner_q];
  // Value presented by whoever owns the display during this cycle
  assign owner_data = data_in[{owner_q, 4'b0000} +: 16];

  // Arbitration FSM with dwell timer; all outputs registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= 4'b0000;
      owner_q  <= 2'd3;          // first search after reset starts at 0
      blank_q  <= 1'b1;
      dwell_q  <= '0;
      digits_q <= 16'h0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Digits are frozen while idle; only a new request wakes us up.
          if (rr_found) begin
            state_q <= S_OWN;
            grant_q <= rr_onehot;
            owner_q <= rr_idx;
            dwell_q <= '0;
            blank_q <= 1'b0;
          end
        end
        S_OWN: begin
          // Track the live value of the owner of this cycle; a switch at
          // this edge therefore shows the new owner one cycle later.
          digits_q <= owner_data;
          if (!owner_req) begin
            // A release always wins over dwell expiry.
            if (rr_found) begin
              grant_q <= rr_onehot;  // hand over with no idle gap
              owner_q <= rr_idx;
              dwell_q <= '0;
            end else begin
              state_q <= S_IDLE;
              grant_q <= 4'b0000;
              blank_q <= 1'b1;
              dwell_q <= '0;
            end
          end else if (dwell_q == DWELL_LAST) begin
            // Owner still requesting, so rr_found is guaranteed; it keeps
            // the grant only if nobody else is waiting.
            grant_q <= rr_onehot;
            owner_q <= rr_idx;
            dwell_q <= '0;
          end else begin
            dwell_q <= dwell_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 4'b0000;
          blank_q <= 1'b1;
          dwell_q <= '0;
        end
      endcase
    end
  end

  // Free-running scan divider; tick is registered so it lands one cycle
  // after the terminal count and is independent of arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      scan_tick_q <= (scan_cnt_q == SCAN_LAST);
      scan_cnt_q  <= (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    end
  end

  assign grant     = grant_q;
  assign owner     = owner_q;
  assign blank     = blank_q;
  assign num_C3    = digits_q[15:12];
  assign num_C2    = digits_q[11:8];
  assign num_C1    = digits_q[7:4];
  assign num_C0    = digits_q[3:0];
  assign scan_tick = scan_tick_q;

endmodule

// File: doc/nixie_display_ctrl.md
# nixie_display_ctrl

Arbitrating controller for the 4-digit nixie/seven-segment scanner. Up to four requesters (register viewer, PC monitor, ALU debug, I/O) each present a 16-bit value. The block grants the display to one requester at a time, round-robin with a minimum dwell time, and drives the four BCD/hex digit nibbles consumed by the scanner. It also generates the scan-rate tick that paces digit multiplexing.

## Interface
- HOLD_CYCLES, 50_000_000: minimum dwell per owner in clk cycles (≥2).
- SCAN_DIV, 50_000: scan tick period in clk cycles (≥2).

- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  request vector; req[i] high = requester i wants the display.
- data_in  in  64  requester i value at data_in[16*i+15:16*i]. Nibble 3 is the MSB.
- grant  out  4  one-hot owner, or 0 when idle.
- owner  out  2  index of the current or last owner.
- num_C3, num_C2, num_C1, num_C0  out  4 each  digit nibbles taken from the owner's value (C3 = bits 15:12).
- blank  out  1  high = no owner; the display must be blanked.
- scan_tick  out  1  one-cycle pulse every SCAN_DIV cycles; clock enable for the scanner.

## Operation
- State machine has two states:
  - IDLE: grant = 0.
  - OWN: grant one-hot.
- Round-robin search starts at index owner+1, wraps 3→0 and ends at owner itself. The lowest distance from the start wins.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise: at the edge, grant the RR winner, load owner, clear dwell_cnt, set blank = 0, go to OWN.
- OWN, evaluated each edge in priority order:
  1. req[owner] = 0 and other requests are pending: grant the RR winner directly, with no idle gap, and clear dwell_cnt.
  2. req[owner] = 0 and no other requests: go to IDLE, set grant = 0 and blank = 1. Digits hold their last value.
  3. dwell_cnt == HOLD_CYCLES-1: run RR over req. A different winner gets the grant. If the winner is the current owner, it keeps the grant. Either way, clear dwell_cnt.
  4. Otherwise, dwell_cnt += 1.
- Digits: in OWN, each edge loads num_C3..C0 from data_in of the owner current during that cycle. Live data is tracked with 1-cycle latency.
- Digits do not update in IDLE.
- dwell_cnt width is clog2(HOLD_CYCLES). It never exceeds HOLD_CYCLES-1.
- scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - scan_tick is registered: high during the cycle after scan_cnt == SCAN_DIV-1.
  - scan_cnt is independent of arbitration state.

## Timing
- Reset values: state IDLE, grant 0, owner 3 (so the first search starts at 0), num_C3..C0 0, blank 1, scan_tick 0, dwell_cnt 0, scan_cnt 0.
- rst has priority over all other activity, including mid-dwell.
- Latency:
  - req rising in cycle N (IDLE) gives grant in cycle N+1.
  - Owner data appears on num_* in cycle N+2.
  - blank falls in cycle N+1.
- An owner switch at edge E changes grant/owner in cycle E+1. The new owner's digits appear in cycle E+2. In cycle E+1 the digits still show the old owner's value.
- A non-pre-empted owner holds the grant for exactly HOLD_CYCLES cycles when competitors are waiting.
- A competitor asserting mid-dwell waits for expiry.
- The owner dropping req takes effect at the next edge. Dwell is not enforced against a release.
- Simultaneous release and dwell expiry: treated as a release (rule 1/2).
- grant is never multi-hot. grant == 0 iff blank == 1.
- scan_tick is first high in cycle SCAN_DIV after reset release, then every SCAN_DIV cycles.

## Test plan
Benches use HOLD_CYCLES=8 and SCAN_DIV=4.
- Reset, then idle for 20 cycles → grant=0, blank=1, num_*=0, scan_tick high in cycles 4, 8, 12, 16, 20.
- req=4'b0100, data_in[47:32]=16'h1A2B → grant=4'b0100 and owner=2 one cycle later. num_C3..C0 = 1,A,2,B one cycle after that. blank=0.
- req=4'b1011 from idle with owner=3 after reset → grant sequence 0001, 0010, 1000, 0001, each held 8 cycles with back-to-back switches.
- req=4'b0001 alone for 30 cycles → grant stays 0001 through dwell expiries. Changing data_in[15:0] to 16'h0042 → num = 0,0,4,2 one cycle later.
- Owner 1 drops req at dwell count 3 while req[2]=1 → grant=0100 next cycle. With no others pending → grant=0, blank=1, digits frozen.
- rst asserted mid-dwell while owning with scan_cnt=2 → next cycle all outputs at reset values. The scan tick period restarts from 0.
